llc_bus_agent: RTL and testbench

Synthesizable LLC-side bus agent that replaces the behavioural bus-operation and snoop-reporting functions with a registered datapath. It queues bus requests from the LLC controller and issues them one at a time on the shared bus under grant. It collects snoop responses from N peer caches, or emulates them from address LSBs, and returns a combined snoop result to the controller. It keeps saturating per-operation statistics counters.

---
 rtl/llc_bus_agent_pkg.sv | 64 ++++++
 rtl/llc_bus_agent_if.sv | 50 +++++
 rtl/llc_bus_agent_fifo.sv | 50 +++++
 rtl/llc_bus_agent.sv | 176 +++++++++++++++++
 tb/tb_llc_bus_agent.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_bus_agent_pkg.sv
// Shared types and helpers for the LLC bus agent: bus operations, snoop results,
// agent FSM states and the snoop reduction used by the response path.
package llc_bus_agent_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_READ  = 3'b001,
      OP_WRITE = 3'b010,
      OP_INVAL = 3'b011,
      OP_RWIM  = 3'b100
   } bus_operation_e;

   typedef enum logic [1:0] {
      SNP_NOHIT = 2'b00,
      SNP_HIT   = 2'b01,
      SNP_HITM  = 2'b10,
      SNP_RSVD  = 2'b11
   } snoop_result_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_SNOOP,
      ST_RESP
   } agent_state_e;

   // Upper bound on peer count handled by combine_snoop; callers zero-extend.
   localparam int MAX_SNOOPERS = 16;

   function automatic logic is_legal_op(input logic [2:0] op);
      case (op)
         3'b001, 3'b010, 3'b011, 3'b100: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic snoop_result_e combine_snoop(
      input logic [2*MAX_SNOOPERS-1:0] res,
      input logic [MAX_SNOOPERS-1:0]   mask
   );
      logic any_hit;
      logic any_hitm;
      any_hit  = 1'b0;
      any_hitm = 1'b0;
      for (int i = 0; i < MAX_SNOOPERS; i++) begin
         if (mask[i]) begin
            if (res[2*i +: 2] == SNP_HITM)     any_hitm = 1'b1;
            else if (res[2*i +: 2] == SNP_HIT) any_hit  = 1'b1;
         end
      end
      if (any_hitm)     return SNP_HITM;
      else if (any_hit) return SNP_HIT;
      else              return SNP_NOHIT;
   endfunction

   function automatic snoop_result_e emulate_snoop(input logic [1:0] lsb);
      case (lsb)
         2'b00:   return SNP_HIT;
         2'b01:   return SNP_HITM;
         default: return SNP_NOHIT;
      endcase
   endfunction

endpackage

// File: rtl/llc_bus_agent_if.sv
// Request, bus, snoop and response signals of the LLC bus agent.
// master = the agent itself; slave = controller, arbiter and peer caches.
interface llc_bus_agent_if #(
   parameter int ADDR_W       = 32,
   parameter int ID_W         = 4,
   parameter int NUM_SNOOPERS = 3
);
   logic                      req_valid;
   logic                      req_ready;
   logic [2:0]                req_op;
   logic [ADDR_W-1:0]         req_addr;
   logic [ID_W-1:0]           req_id;
   logic                      req_err;

   logic                      bus_valid;
   logic                      bus_grant;
   logic [2:0]                bus_op;
   logic [ADDR_W-1:0]         bus_addr;
   logic [ID_W-1:0]           bus_id;

   logic [NUM_SNOOPERS-1:0]   snoop_valid;
   logic [2*NUM_SNOOPERS-1:0] snoop_result;

   logic                      resp_valid;
   logic                      resp_ready;
   logic [2:0]                resp_op;
   logic [ADDR_W-1:0]         resp_addr;
   logic [1:0]                resp_snoop;
   logic                      resp_timeout;

   modport master (
      input  req_valid, req_op, req_addr, req_id,
      output req_ready, req_err,
      output bus_valid, bus_op, bus_addr, bus_id,
      input  bus_grant,
      input  snoop_valid, snoop_result,
      output resp_valid, resp_op, resp_addr, resp_snoop, resp_timeout,
      input  resp_ready
   );

   modport slave (
      output req_valid, req_op, req_addr, req_id,
      input  req_ready, req_err,
      input  bus_valid, bus_op, bus_addr, bus_id,
      output bus_grant,
      output snoop_valid, snoop_result,
      input  resp_valid, resp_op, resp_addr, resp_snoop, resp_timeout,
      output resp_ready
   );
endinterface

// File: rtl/llc_bus_agent_fifo.sv
// Request FIFO for the bus agent. ready_o is registered from the next count,
// so it is low in reset and never bypasses a same-cycle pop at full.
module llc_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             ready_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             ready_q;
   logic             do_push, do_pop;

   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign count_d = count_q + CW'(do_push) - CW'(do_pop);

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign ready_o = ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         ready_q <= (count_d != CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/llc_bus_agent.sv
// LLC bus agent: queues controller requests, issues them on the bus under grant,
// gathers (or emulates) peer snoops and returns a combined result.
//   state    | meaning
//   ST_IDLE  | waiting for a queued request; pops head into current-transaction regs
//   ST_ISSUE | bus_valid high, op/addr/id held until grant
//   ST_SNOOP | emulate: one cycle; external: collect peers until all seen or timeout
//   ST_RESP  | resp_valid high, result held until resp_ready
module llc_bus_agent
   import llc_bus_agent_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int ID_W          = 4,
   parameter int DEPTH         = 4,
   parameter int NUM_SNOOPERS  = 3,
   parameter int SNOOP_TIMEOUT = 8,
   parameter int EMULATE_SNOOP = 1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   llc_bus_agent_if.master  bus_if,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] cnt_read,
   output logic [CNT_W-1:0] cnt_write,
   output logic [CNT_W-1:0] cnt_inval,
   output logic [CNT_W-1:0] cnt_rwim
);
   localparam int REQ_W = 3 + ADDR_W + ID_W;
   localparam int TMR_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

   agent_state_e              state_q;
   logic [2:0]                cur_op_q;
   logic [ADDR_W-1:0]         cur_addr_q;
   logic [ID_W-1:0]           cur_id_q;
   logic                      bus_valid_q, resp_valid_q, resp_timeout_q, req_err_q;
   snoop_result_e             resp_snoop_q;
   logic [TMR_W-1:0]          timer_q;
   logic [NUM_SNOOPERS-1:0]   coll_q, coll_d;
   logic [2*NUM_SNOOPERS-1:0] res_q, res_d;
   logic [2*MAX_SNOOPERS-1:0] res_vec;
   logic [MAX_SNOOPERS-1:0]   res_mask;
   snoop_result_e             snoop_comb;

   logic             fifo_ready, fifo_empty, fifo_pop, accept, push;
   logic [REQ_W-1:0] fifo_rdata;

   assign accept   = bus_if.req_valid && fifo_ready;
   assign push     = accept && is_legal_op(bus_if.req_op);
   assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

   llc_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({bus_if.req_op, bus_if.req_addr, bus_if.req_id}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .ready_o (fifo_ready)
   );

   // First response from each peer is sticky; later pulses in the same SNOOP are ignored.
   always_comb begin
      coll_d = coll_q | bus_if.snoop_valid;
      res_d  = res_q;
      for (int i = 0; i < NUM_SNOOPERS; i++) begin
         if (bus_if.snoop_valid[i] && !coll_q[i]) res_d[2*i +: 2] = bus_if.snoop_result[2*i +: 2];
      end
      res_vec  = '0;
      res_mask = '0;
      res_vec[2*NUM_SNOOPERS-1:0] = res_d;
      res_mask[NUM_SNOOPERS-1:0]  = coll_d;
   end

   assign snoop_comb = combine_snoop(res_vec, res_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cur_op_q       <= '0;
         cur_addr_q     <= '0;
         cur_id_q       <= '0;
         bus_valid_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_snoop_q   <= SNP_NOHIT;
         resp_timeout_q <= 1'b0;
         timer_q        <= '0;
         coll_q         <= '0;
         res_q          <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (!fifo_empty) begin
               {cur_op_q, cur_addr_q, cur_id_q} <= fifo_rdata;
               bus_valid_q <= 1'b1;
               state_q     <= ST_ISSUE;
            end
            ST_ISSUE: if (bus_if.bus_grant) begin
               bus_valid_q <= 1'b0;
               timer_q     <= TMR_W'(SNOOP_TIMEOUT - 1);
               coll_q      <= '0;
               res_q       <= '0;
               state_q     <= ST_SNOOP;
            end
            ST_SNOOP: begin
               if (EMULATE_SNOOP != 0) begin
                  resp_snoop_q   <= emulate_snoop(cur_addr_q[1:0]);
                  resp_timeout_q <= 1'b0;
                  resp_valid_q   <= 1'b1;
                  state_q        <= ST_RESP;
               end else begin
                  coll_q <= coll_d;
                  res_q  <= res_d;
                  if (&coll_d || timer_q == '0) begin
                     resp_snoop_q   <= snoop_comb;
                     resp_timeout_q <= !(&coll_d);
                     resp_valid_q   <= 1'b1;
                     state_q        <= ST_RESP;
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                  end
               end
            end
            ST_RESP: if (bus_if.resp_ready) begin
               resp_valid_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) req_err_q <= 1'b0;
      else        req_err_q <= accept && !is_legal_op(bus_if.req_op);
   end

   logic [CNT_W-1:0] cnt_q [4];
   logic [1:0]       cnt_sel;

   always_comb begin
      cnt_sel = 2'd3;
      case (cur_op_q)
         3'b001:  cnt_sel = 2'd0;
         3'b010:  cnt_sel = 2'd1;
         3'b011:  cnt_sel = 2'd2;
         default: cnt_sel = 2'd3;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else if (cnt_clear) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else if (state_q == ST_ISSUE && bus_if.bus_grant && cnt_q[cnt_sel] != '1) begin
         cnt_q[cnt_sel] <= cnt_q[cnt_sel] + CNT_W'(1);
      end
   end

   assign cnt_read  = cnt_q[0];
   assign cnt_write = cnt_q[1];
   assign cnt_inval = cnt_q[2];
   assign cnt_rwim  = cnt_q[3];

   assign bus_if.req_ready    = fifo_ready;
   assign bus_if.req_err      = req_err_q;
   assign bus_if.bus_valid    = bus_valid_q;
   assign bus_if.bus_op       = cur_op_q;
   assign bus_if.bus_addr     = cur_addr_q;
   assign bus_if.bus_id       = cur_id_q;
   assign bus_if.resp_valid   = resp_valid_q;
   assign bus_if.resp_op      = cur_op_q;
   assign bus_if.resp_addr    = cur_addr_q;
   assign bus_if.resp_snoop   = resp_snoop_q;
   assign bus_if.resp_timeout = resp_timeout_q;
endmodule

// File: tb/tb_llc_bus_agent.sv
// Directed bench: one emulate-mode agent and one external-snoop agent side by side.
module tb_llc_bus_agent;
   import llc_bus_agent_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic e_clr, x_clr;
   logic [31:0] e_rd, e_wr, e_inv, e_rwim;
   logic [31:0] x_rd, x_wr, x_inv, x_rwim;
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   llc_bus_agent_if #(.ADDR_W(32), .ID_W(4), .NUM_SNOOPERS(3)) e_if ();
   llc_bus_agent_if #(.ADDR_W(32), .ID_W(4), .NUM_SNOOPERS(3)) x_if ();

   llc_bus_agent #(.ADDR_W(32), .ID_W(4), .DEPTH(4), .NUM_SNOOPERS(3), .SNOOP_TIMEOUT(8),
                   .EMULATE_SNOOP(1), .CNT_W(32)) u_emu (
      .clk(clk), .rst_n(rst_n), .bus_if(e_if), .cnt_clear(e_clr),
      .cnt_read(e_rd), .cnt_write(e_wr), .cnt_inval(e_inv), .cnt_rwim(e_rwim));

   llc_bus_agent #(.ADDR_W(32), .ID_W(4), .DEPTH(4), .NUM_SNOOPERS(3), .SNOOP_TIMEOUT(8),
                   .EMULATE_SNOOP(0), .CNT_W(32)) u_ext (
      .clk(clk), .rst_n(rst_n), .bus_if(x_if), .cnt_clear(x_clr),
      .cnt_read(x_rd), .cnt_write(x_wr), .cnt_inval(x_inv), .cnt_rwim(x_rwim));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] id);
      e_if.req_valid = 1'b1;
      e_if.req_op    = op;
      e_if.req_addr  = addr;
      e_if.req_id    = id;
   endtask

   task automatic set_x(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] id);
      x_if.req_valid = 1'b1;
      x_if.req_op    = op;
      x_if.req_addr  = addr;
      x_if.req_id    = id;
   endtask

   task automatic wait_e(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] snp);
      int n;
      n = 0;
      while (e_if.resp_valid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, e_if.resp_valid, 1);
      check({tag, "_op"}, e_if.resp_op, op);
      check({tag, "_addr"}, e_if.resp_addr, addr);
      check({tag, "_snoop"}, e_if.resp_snoop, snp);
      tick();
   endtask

   logic [2:0]  f_op   [6];
   logic [31:0] f_addr [6];
   logic [1:0]  f_snp  [6];
   logic        f_rdy  [6];

   initial begin
      f_op   = '{OP_READ, OP_WRITE, OP_INVAL, OP_RWIM, OP_READ, OP_WRITE};
      f_addr = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2005, 32'h2004};
      f_snp  = '{SNP_HIT, SNP_HITM, SNP_NOHIT, SNP_NOHIT, SNP_HITM, SNP_HIT};
      f_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      e_if.req_valid = 0; e_if.req_op = 0; e_if.req_addr = 0; e_if.req_id = 0;
      e_if.bus_grant = 0; e_if.snoop_valid = 0; e_if.snoop_result = 0; e_if.resp_ready = 0;
      x_if.req_valid = 0; x_if.req_op = 0; x_if.req_addr = 0; x_if.req_id = 0;
      x_if.bus_grant = 0; x_if.snoop_valid = 0; x_if.snoop_result = 0; x_if.resp_ready = 0;
      e_clr = 0; x_clr = 0;

      // reset state
      #12;
      check("rst_bus_valid", e_if.bus_valid, 0);
      check("rst_resp_valid", e_if.resp_valid, 0);
      check("rst_req_ready", e_if.req_ready, 0);
      check("rst_req_err", e_if.req_err, 0);
      check("rst_cnt_read", e_rd, 0);
      check("rst_x_resp_valid", x_if.resp_valid, 0);
      #5 rst_n = 1'b1;
      tick();
      check("ready_after_rst", e_if.req_ready, 1);

      // emulate READ latency
      e_if.bus_grant = 1; e_if.resp_ready = 1;
      set_e(OP_READ, 32'h0000_1000, 4'd3);
      tick();
      e_if.req_valid = 0;
      check("t1_n1_bus_valid", e_if.bus_valid, 0);
      tick();
      check("t1_n2_bus_valid", e_if.bus_valid, 1);
      check("t1_n2_bus_op", e_if.bus_op, OP_READ);
      check("t1_n2_bus_addr", e_if.bus_addr, 32'h1000);
      check("t1_n2_bus_id", e_if.bus_id, 3);
      tick();
      check("t1_n3_bus_valid", e_if.bus_valid, 0);
      check("t1_n3_resp_valid", e_if.resp_valid, 0);
      check("t1_n3_cnt_read", e_rd, 1);
      tick();
      check("t1_n4_resp_valid", e_if.resp_valid, 1);
      check("t1_n4_resp_snoop", e_if.resp_snoop, SNP_HIT);
      check("t1_n4_resp_op", e_if.resp_op, OP_READ);
      check("t1_n4_resp_addr", e_if.resp_addr, 32'h1000);
      check("t1_n4_resp_timeout", e_if.resp_timeout, 0);
      tick();
      check("t1_n5_resp_valid", e_if.resp_valid, 0);

      // back-to-back RWIM, WRITE
      set_e(OP_RWIM, 32'h0000_1001, 4'd1);
      tick();
      set_e(OP_WRITE, 32'h0000_1002, 4'd2);
      tick();
      e_if.req_valid = 0;
      wait_e("t2_rwim", OP_RWIM, 32'h1001, SNP_HITM);
      wait_e("t2_write", OP_WRITE, 32'h1002, SNP_NOHIT);
      check("t2_cnt_rwim", e_rwim, 1);
      check("t2_cnt_write", e_wr, 1);
      check("t2_cnt_read", e_rd, 1);

      // fill with grant low: r0 goes in flight, r1..r4 fill the FIFO, r5 is refused
      e_if.bus_grant = 0;
      for (int k = 0; k < 6; k++) begin
         set_e(f_op[k], f_addr[k], 4'(k));
         check($sformatf("fill_ready_%0d", k), e_if.req_ready, f_rdy[k]);
         if (k >= 2) begin
            check($sformatf("fill_bus_valid_%0d", k), e_if.bus_valid, 1);
            check($sformatf("fill_bus_op_%0d", k), e_if.bus_op, OP_READ);
         end
         tick();
      end
      e_if.req_valid = 0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("hold_bus_addr_%0d", k), e_if.bus_addr, 32'h2000);
         check($sformatf("hold_ready_%0d", k), e_if.req_ready, 0);
         tick();
      end
      e_if.bus_grant = 1;
      for (int k = 0; k < 5; k++) wait_e($sformatf("fill_resp_%0d", k), f_op[k], f_addr[k], f_snp[k]);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("fill_drain_resp_%0d", k), e_if.resp_valid, 0);
         check($sformatf("fill_drain_bus_%0d", k), e_if.bus_valid, 0);
         tick();
      end
      check("fill_cnt_read", e_rd, 3);
      check("fill_cnt_write", e_wr, 2);
      check("fill_cnt_inval", e_inv, 1);
      check("fill_cnt_rwim", e_rwim, 2);

      // illegal op
      set_e(3'b111, 32'h3000, 4'd5);
      check("ill_ready", e_if.req_ready, 1);
      tick();
      e_if.req_valid = 0;
      check("ill_err_pulse", e_if.req_err, 1);
      tick();
      check("ill_err_clear", e_if.req_err, 0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("ill_no_bus_%0d", k), e_if.bus_valid, 0);
         tick();
      end
      check("ill_cnt_write", e_wr, 2);

      // counter clear coincident with grant
      set_e(OP_READ, 32'h6003, 4'd7);
      tick();
      e_if.req_valid = 0;
      tick();
      check("clr_issue_valid", e_if.bus_valid, 1);
      e_clr = 1;
      tick();
      e_clr = 0;
      check("clr_cnt_read", e_rd, 0);
      check("clr_cnt_rwim", e_rwim, 0);
      wait_e("clr_resp", OP_READ, 32'h6003, SNP_NOHIT);
      check("clr_cnt_read_after", e_rd, 0);

      // external: three peers in different cycles
      x_if.bus_grant = 1; x_if.resp_ready = 1;
      set_x(OP_READ, 32'h4000, 4'd1);
      tick();
      x_if.req_valid = 0;
      tick();
      check("x4_issue", x_if.bus_valid, 1);
      tick();
      x_if.snoop_valid = 3'b001; x_if.snoop_result = 6'b00_00_00;
      tick();
      x_if.snoop_valid = 3'b010; x_if.snoop_result = 6'b00_01_00;
      tick();
      x_if.snoop_valid = 3'b100; x_if.snoop_result = 6'b10_00_00;
      check("x4_not_yet", x_if.resp_valid, 0);
      tick();
      x_if.snoop_valid = 0; x_if.snoop_result = 0;
      check("x4_resp_valid", x_if.resp_valid, 1);
      check("x4_resp_snoop", x_if.resp_snoop, SNP_HITM);
      check("x4_resp_timeout", x_if.resp_timeout, 0);
      check("x4_resp_addr", x_if.resp_addr, 32'h4000);
      tick();
      check("x4_resp_done", x_if.resp_valid, 0);
      check("x4_cnt_read", x_rd, 1);

      // external: only peer 0 answers; a HITM offered during ISSUE must be ignored
      set_x(OP_INVAL, 32'h5000, 4'd2);
      tick();
      x_if.req_valid = 0;
      tick();
      x_if.snoop_valid = 3'b010; x_if.snoop_result = 6'b00_10_00;
      tick();
      x_if.snoop_valid = 0; x_if.snoop_result = 0;
      tick();
      x_if.snoop_valid = 3'b001; x_if.snoop_result = 6'b00_00_01;
      tick();
      x_if.snoop_valid = 0; x_if.snoop_result = 0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("x5_wait_%0d", k), x_if.resp_valid, 0);
         tick();
      end
      check("x5_resp_valid", x_if.resp_valid, 1);
      check("x5_resp_snoop", x_if.resp_snoop, SNP_HIT);
      check("x5_resp_timeout", x_if.resp_timeout, 1);
      check("x5_resp_op", x_if.resp_op, OP_INVAL);
      tick();
      check("x5_resp_done", x_if.resp_valid, 0);
      check("x5_cnt_inval", x_inv, 1);

      // reset during SNOOP with one request still queued
      set_x(OP_READ, 32'h7000, 4'd3);
      tick();
      set_x(OP_WRITE, 32'h7004, 4'd4);
      tick();
      x_if.req_valid = 0;
      tick();
      tick();
      check("rs_pre_cnt_read", x_rd, 2);
      #2 rst_n = 1'b0;
      #1;
      check("rs_bus_valid", x_if.bus_valid, 0);
      check("rs_resp_valid", x_if.resp_valid, 0);
      check("rs_req_ready", x_if.req_ready, 0);
      check("rs_cnt_read", x_rd, 0);
      check("rs_cnt_inval", x_inv, 0);
      tick();
      #3 rst_n = 1'b1;
      tick();
      check("rs_ready_after", x_if.req_ready, 1);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rs_flushed_bus_%0d", k), x_if.bus_valid, 0);
         check($sformatf("rs_flushed_resp_%0d", k), x_if.resp_valid, 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
